// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scan driver: snapshots the packed BCD bus once per
// frame, then strobes one digit per slot with leading-zero blanking and a guard gap.
module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 49_999,
  parameter int unsigned GUARD          = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic                    frame_done
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned P_W   = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam int unsigned S_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [P_W-1:0] P_MAX   = P_W'(SCAN_DIV);
  localparam logic [P_W-1:0] P_GUARD = P_W'(GUARD);
  localparam logic [S_W-1:0] S_MAX   = S_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  logic [P_W-1:0]        p_q;
  logic [S_W-1:0]        slot_q;
  logic [BCD_W-1:0]      bcd_q;
  logic [NUM_DIGITS-1:0] dp_q;

  logic                  load;
  logic [BCD_W-1:0]      bcd_eff;
  logic [NUM_DIGITS-1:0] dp_eff;
  logic [NUM_DIGITS-1:0] upper_nz;
  logic [3:0]            digit;
  logic                  dp_bit;
  logic                  blank;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign load = (p_q == '0) && (slot_q == '0);

  // Prescaler and slot counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      slot_q <= '0;
    end else if (p_q == P_MAX) begin
      p_q    <= '0;
      slot_q <= (slot_q == S_MAX) ? '0 : slot_q + S_W'(1);
    end else begin
      p_q    <= p_q + P_W'(1);
    end
  end

  // Frame snapshot of the digit and decimal-point buses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      dp_q  <= '0;
    end else if (load) begin
      bcd_q <= bcd_in;
      dp_q  <= dp_in;
    end
  end

  // In the load cycle the fresh bus is decoded directly so the whole frame shows one snapshot
  always_comb begin
    bcd_eff  = load ? bcd_in : bcd_q;
    dp_eff   = load ? dp_in : dp_q;
    upper_nz = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      if (i == int'(NUM_DIGITS) - 1) upper_nz[i] = |bcd_eff[4*i +: 4];
      else                           upper_nz[i] = upper_nz[i+1] | (|bcd_eff[4*i +: 4]);
    end
  end

  always_comb begin
    digit   = '0;
    dp_bit  = 1'b0;
    blank   = 1'b0;
    sel_nxt = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (slot_q == S_W'(i)) begin
        digit      = bcd_eff[4*i +: 4];
        dp_bit     = dp_eff[i];
        blank      = BLANK_LEADING && (i != 0) && !upper_nz[i];
        sel_nxt[i] = (p_q >= P_GUARD);
      end
    end
    seg_nxt = blank ? 7'h00 : seg_decode(digit);
  end

  // Registered, polarity-adjusted outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dp         <= SEG_ACTIVE_LOW;
      sel        <= SEL_OFF;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nxt ^ SEG_OFF;
      dp         <= dp_bit ^ SEG_ACTIVE_LOW;
      sel        <= sel_nxt ^ SEL_OFF;
      frame_done <= load;
    end
  end

endmodule
